// File: rtl/pipearch_common.sv
// Shared definitions for the pipearch CCI-P front end: default sizing and the
// layout of the read-request mdata tag.
package pipearch_common;

  localparam int NUM_REQ_DEFAULT = 4;
  localparam int MAX_OUT_DEFAULT = 64;
  localparam int MDATA_W         = 16;
  localparam int ADDR_W          = 42;
  localparam int DATA_W          = 512;
  localparam int ID_W_DEFAULT    = $clog2(NUM_REQ_DEFAULT);

  typedef struct packed {
    logic [MDATA_W-ID_W_DEFAULT-1:0] seq;
    logic [ID_W_DEFAULT-1:0]         id;
  } t_rd_mdata;

  // Width-generic packing of {seq, id} for arbiters not built at the default size.
  function automatic logic [MDATA_W-1:0] pack_mdata(input logic [MDATA_W-1:0] seq,
                                                    input logic [MDATA_W-1:0] id,
                                                    input int id_w);
    logic [MDATA_W-1:0] mask;
    mask = (MDATA_W'(1) << id_w) - MDATA_W'(1);
    return (seq << id_w) | (id & mask);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over an N-wide request mask. The grant is combinational;
// the search pointer moves to one past the winner whenever a grant is given.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] cand;

  // N is a power of two, so pointer arithmetic wraps naturally.
  always_comb begin
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int off = 0; off < N; off++) begin
      cand = ptr + IDX_W'(off);
      if (!gnt_valid && en && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
    if (gnt_valid) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (gnt_valid) ptr <= gnt_idx + 1'b1;
  end

endmodule

// File: rtl/ccip_rd_arbiter.sv
// Shares the CCI-P c0 read channel among NUM_REQ read engines: tags mdata with
// the requester id, caps per-requester in-flight reads and routes responses back.
module ccip_rd_arbiter
  import pipearch_common::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEFAULT,
  parameter  int MAX_OUT = MAX_OUT_DEFAULT,
  localparam int ID_W    = $clog2(NUM_REQ),
  localparam int CNT_W   = $clog2(MAX_OUT) + 1,
  localparam int SEQ_W   = MDATA_W - ID_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            c0TxAlmFull,
  output logic                            c0tx_valid,
  output logic [ADDR_W-1:0]               c0tx_addr,
  output logic [MDATA_W-1:0]              c0tx_mdata,
  input  logic                            c0rx_valid,
  input  logic [MDATA_W-1:0]              c0rx_mdata,
  input  logic [DATA_W-1:0]               c0rx_data,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_W-1:0]               rsp_data,
  output logic [NUM_REQ-1:0][CNT_W-1:0]   outstanding,
  output logic                            idle,
  output logic                            err_underflow
);

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] gnt;
  logic [NUM_REQ-1:0] rsp_hit;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_valid;
  logic [SEQ_W-1:0]   seq;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = req_valid[i] && (outstanding[i] < CNT_W'(MAX_OUT));
  end

  // Response routing uses only the id field; the sequence bits are debug-only.
  always_comb begin
    rsp_hit = '0;
    if (c0rx_valid) rsp_hit = NUM_REQ'(1) << c0rx_mdata[ID_W-1:0];
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .en        (!reset && !c0TxAlmFull),
    .req       (eligible),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  assign req_ready = gnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      c0tx_valid <= 1'b0;
      c0tx_addr  <= '0;
      c0tx_mdata <= '0;
      seq        <= '0;
    end else begin
      c0tx_valid <= gnt_valid;
      if (gnt_valid) begin
        c0tx_addr  <= req_addr[gnt_idx];
        c0tx_mdata <= pack_mdata(MDATA_W'(seq), MDATA_W'(gnt_idx), ID_W);
        seq        <= seq + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= rsp_hit;
      if (c0rx_valid) rsp_data <= c0rx_data;
    end
  end

  // A grant and a response to the same requester in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && !rsp_hit[i])
          outstanding[i] <= outstanding[i] + 1'b1;
        else if (rsp_hit[i] && !gnt[i] && outstanding[i] != '0)
          outstanding[i] <= outstanding[i] - 1'b1;
        if (rsp_hit[i] && outstanding[i] == '0)
          err_underflow <= 1'b1;
      end
    end
  end

  always_comb begin
    idle = ~|req_valid;
    for (int i = 0; i < NUM_REQ; i++)
      if (outstanding[i] != '0) idle = 1'b0;
  end

endmodule

// File: tb/tb_ccip_rd_arbiter.sv
// Directed bench for ccip_rd_arbiter: expected requests and responses are queued
// as stimulus is applied and a negedge monitor checks them as the DUT emits them.
module tb_ccip_rd_arbiter;
  import pipearch_common::*;

  localparam int NR = 4;
  localparam int MO = 64;
  localparam int CW = 7;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NR-1:0]             req_valid;
  logic [NR-1:0][ADDR_W-1:0] req_addr;
  logic [NR-1:0]             req_ready;
  logic                      c0TxAlmFull;
  logic                      c0tx_valid;
  logic [ADDR_W-1:0]         c0tx_addr;
  logic [MDATA_W-1:0]        c0tx_mdata;
  logic                      c0rx_valid;
  logic [MDATA_W-1:0]        c0rx_mdata;
  logic [DATA_W-1:0]         c0rx_data;
  logic [NR-1:0]             rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic [NR-1:0][CW-1:0]     outstanding;
  logic                      idle;
  logic                      err_underflow;

  ccip_rd_arbiter #(.NUM_REQ(NR), .MAX_OUT(MO)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .c0TxAlmFull   (c0TxAlmFull),
    .c0tx_valid    (c0tx_valid),
    .c0tx_addr     (c0tx_addr),
    .c0tx_mdata    (c0tx_mdata),
    .c0rx_valid    (c0rx_valid),
    .c0rx_mdata    (c0rx_mdata),
    .c0rx_data     (c0rx_data),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .outstanding   (outstanding),
    .idle          (idle),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                 cyc;
    logic [ADDR_W-1:0]  addr;
    logic [MDATA_W-1:0] mdata;
  } tx_t;

  typedef struct {
    int                cyc;
    logic [NR-1:0]     vec;
    logic [DATA_W-1:0] data;
  } rsp_t;

  tx_t  txQ[$];
  rsp_t rspQ[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   expSeq   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [ADDR_W-1:0] addrFor(input int id);
    return 42'h1_0000_0000 + ADDR_W'(id * 256 + 7);
  endfunction

  function automatic logic [DATA_W-1:0] lineFor(input int key);
    return {16{32'hA5A5_0000 + 32'(key)}};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drives one cycle of inputs at the negedge; a response input queues its expected strobe.
  task automatic applyStimulus(input logic [NR-1:0] v, input logic af, input logic rxv,
                               input int rxid, input int key);
    rsp_t r;
    @(negedge clk);
    req_valid   = v;
    c0TxAlmFull = af;
    c0rx_valid  = rxv;
    c0rx_mdata  = 16'hABC0 | 16'(rxid);
    c0rx_data   = lineFor(key);
    #1;
    if (rxv) begin
      r.cyc  = cyc + 1;
      r.vec  = NR'(1) << rxid;
      r.data = lineFor(key);
      rspQ.push_back(r);
    end
  endtask

  // id < 0 means no grant this cycle.
  task automatic expectGrant(input int id);
    tx_t       t;
    t_rd_mdata m;
    if (id < 0) begin
      checkOutput("req_ready_none", 64'(req_ready), 64'd0);
    end else begin
      checkOutput("req_ready", 64'(req_ready), 64'(NR'(1) << id));
      m.seq   = 14'(expSeq);
      m.id    = 2'(id);
      t.cyc   = cyc + 1;
      t.addr  = addrFor(id);
      t.mdata = m;
      txQ.push_back(t);
      expSeq++;
    end
  endtask

  task automatic checkCounts(input int c0, input int c1, input int c2, input int c3);
    checkOutput("outstanding0", 64'(outstanding[0]), 64'(c0));
    checkOutput("outstanding1", 64'(outstanding[1]), 64'(c1));
    checkOutput("outstanding2", 64'(outstanding[2]), 64'(c2));
    checkOutput("outstanding3", 64'(outstanding[3]), 64'(c3));
  endtask

  task automatic checkResetState();
    checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
    checkOutput("rst_c0tx_valid", 64'(c0tx_valid), 64'd0);
    checkOutput("rst_c0tx_addr", 64'(c0tx_addr), 64'd0);
    checkOutput("rst_c0tx_mdata", 64'(c0tx_mdata), 64'd0);
    checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("rst_rsp_data_nonzero", 64'(|rsp_data), 64'd0);
    checkOutput("rst_err_underflow", 64'(err_underflow), 64'd0);
    checkCounts(0, 0, 0, 0);
  endtask

  always @(negedge clk) begin : monitor
    tx_t  te;
    rsp_t re;
    if (c0tx_valid) begin
      checks++;
      if (txQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL tx_unexpected: got mdata=%h addr=%h, required no request", c0tx_mdata, c0tx_addr);
      end else begin
        te = txQ.pop_front();
        if (c0tx_addr !== te.addr || c0tx_mdata !== te.mdata || cyc != te.cyc) begin
          failures++;
          $display("[TB] FAIL tx_request: got addr=%h mdata=%h cycle=%0d, required addr=%h mdata=%h cycle=%0d",
                   c0tx_addr, c0tx_mdata, cyc, te.addr, te.mdata, te.cyc);
        end
      end
    end
    if (rsp_valid != '0) begin
      checks++;
      if (rspQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL rsp_unexpected: got rsp_valid=%b, required none", rsp_valid);
      end else begin
        re = rspQ.pop_front();
        if (rsp_valid !== re.vec || rsp_data !== re.data || cyc != re.cyc) begin
          failures++;
          $display("[TB] FAIL rsp_route: got vec=%b data[31:0]=%h cycle=%0d, required vec=%b data[31:0]=%h cycle=%0d",
                   rsp_valid, rsp_data[31:0], cyc, re.vec, re.data[31:0], re.cyc);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    req_valid   = '0;
    c0TxAlmFull = 1'b0;
    c0rx_valid  = 1'b0;
    c0rx_mdata  = '0;
    c0rx_data   = '0;
    for (int i = 0; i < NR; i++) req_addr[i] = addrFor(i);

    repeat (3) @(negedge clk);
    checkResetState();
    checkOutput("rst_idle", 64'(idle), 64'd1);
    reset = 1'b0;

    // All four requesters contend: strict rotation 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b1111, 1'b0, 1'b0, 0, 0);
      expectGrant(k % 4);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0, 0, 0);
    checkCounts(2, 2, 2, 2);
    checkOutput("idle_busy", 64'(idle), 64'd0);

    // Move pointer to 1, then sparse mask 0101 must give 2,0,2.
    applyStimulus(4'b0001, 1'b0, 1'b0, 0, 0);
    expectGrant(0);
    applyStimulus(4'b0101, 1'b0, 1'b0, 0, 0);
    expectGrant(2);
    applyStimulus(4'b0101, 1'b0, 1'b0, 0, 0);
    expectGrant(0);
    applyStimulus(4'b0101, 1'b0, 1'b0, 0, 0);
    expectGrant(2);
    applyStimulus(4'b0000, 1'b0, 1'b0, 0, 0);
    checkCounts(4, 2, 4, 2);

    // Almost-full blocks every grant; on release the pointer index (3) wins.
    for (int k = 0; k < 10; k++) begin
      applyStimulus(4'b1111, 1'b1, 1'b0, 0, 0);
      expectGrant(-1);
    end
    applyStimulus(4'b1111, 1'b0, 1'b0, 0, 0);
    expectGrant(3);

    // Requester 0 fills to the cap of 64, then one response reopens it.
    for (int k = 0; k < 60; k++) begin
      applyStimulus(4'b0001, 1'b0, 1'b0, 0, 0);
      expectGrant(0);
    end
    applyStimulus(4'b0001, 1'b0, 1'b0, 0, 0);
    expectGrant(-1);
    checkOutput("outstanding0_cap", 64'(outstanding[0]), 64'd64);
    applyStimulus(4'b0001, 1'b0, 1'b1, 0, 11);
    expectGrant(-1);
    applyStimulus(4'b0001, 1'b0, 1'b0, 0, 0);
    expectGrant(0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 0, 0);
    checkCounts(64, 2, 4, 3);

    // Grant to 2 and response to 2 in the same cycle.
    applyStimulus(4'b0100, 1'b0, 1'b1, 2, 22);
    expectGrant(2);
    applyStimulus(4'b0000, 1'b0, 1'b0, 0, 0);
    checkOutput("outstanding2_same_cycle", 64'(outstanding[2]), 64'd4);

    // Drain requester 3 to zero, then one extra response underflows.
    for (int k = 0; k < 3; k++) applyStimulus(4'b0000, 1'b0, 1'b1, 3, 30 + k);
    applyStimulus(4'b0000, 1'b0, 1'b1, 3, 33);
    checkOutput("err_before_underflow", 64'(err_underflow), 64'd0);
    checkOutput("outstanding3_drained", 64'(outstanding[3]), 64'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 0, 0);
    checkOutput("err_underflow_set", 64'(err_underflow), 64'd1);
    checkOutput("outstanding3_floor", 64'(outstanding[3]), 64'd0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 0, 0);
    checkOutput("err_underflow_sticky", 64'(err_underflow), 64'd1);

    // Burst, then reset mid-burst with a response arriving on the reset edge.
    applyStimulus(4'b1111, 1'b0, 1'b0, 0, 0);
    expectGrant(3);
    applyStimulus(4'b1111, 1'b0, 1'b0, 0, 0);
    expectGrant(1);
    @(negedge clk);
    reset      = 1'b1;
    c0rx_valid = 1'b1;
    c0rx_mdata = 16'h0002;
    c0rx_data  = lineFor(44);
    #1;
    checkOutput("req_ready_in_reset", 64'(req_ready), 64'd0);
    @(negedge clk);
    checkResetState();
    reset      = 1'b0;
    req_valid  = '0;
    c0rx_valid = 1'b0;
    expSeq     = 0;
    #1;
    checkOutput("idle_after_reset", 64'(idle), 64'd1);

    // Late response to a pre-reset request is routed but underflows.
    applyStimulus(4'b0000, 1'b0, 1'b1, 1, 55);
    applyStimulus(4'b0000, 1'b0, 1'b0, 0, 0);
    checkOutput("err_late_rsp", 64'(err_underflow), 64'd1);
    checkOutput("outstanding1_late", 64'(outstanding[1]), 64'd0);
    applyStimulus(4'b1111, 1'b0, 1'b0, 0, 0);
    expectGrant(0);

    repeat (3) applyStimulus(4'b0000, 1'b0, 1'b0, 0, 0);
    checkOutput("tx_queue_drained", 64'(txQ.size()), 64'd0);
    checkOutput("rsp_queue_drained", 64'(rspQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ccip_rd_arbiter.md
Name: ccip_rd_arbiter

Overview:
- Round-robin arbiter that shares the CCI-P c0 read-request channel among NUM_REQ independent read engines inside pipearch_top.
- Tags each request's mdata with the requester index, throttles on c0TxAlmFull and on a per-requester outstanding cap, and steers read responses back to the issuing requester.
- Sits between the engines and af2cp_sTx.c0 / cp2af_sRx.c0.

Parameters:
NUM_REQ, 4, number of requesters; power of two, 2..8
MAX_OUT, 64, outstanding reads allowed per requester; power of two
ID_W, $clog2(NUM_REQ), requester-id field width in mdata

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
req_valid  in  NUM_REQ  requester i has a read pending
req_addr  in  NUM_REQ x 42  cache-line address per requester
req_ready  out  NUM_REQ  one-hot grant; request i accepted this cycle
c0TxAlmFull  in  1  CCI-P c0 almost-full
c0tx_valid  out  1  read request valid toward CCI-P
c0tx_addr  out  42  granted address
c0tx_mdata  out  16  {zero pad, seq[15-ID_W:0]... see Behaviour}
c0rx_valid  in  1  c0 read response valid (rspValid and resp type = read)
c0rx_mdata  in  16  returned mdata
c0rx_data  in  512  returned line
rsp_valid  out  NUM_REQ  one-hot response strobe per requester
rsp_data  out  512  response line, shared by all requesters
outstanding  out  NUM_REQ x (log2(MAX_OUT)+1)  live in-flight count per requester
idle  out  1  all outstanding counts zero and no request valid
err_underflow  out  1  sticky: response arrived for requester with count 0

Behaviour:
- Reset values: req_ready=0, c0tx_valid=0, c0tx_addr=0, c0tx_mdata=0, rsp_valid=0, rsp_data=0, all outstanding=0, err_underflow=0, rr pointer=0, seq=0.
- Eligible(i) = req_valid[i] && outstanding[i] < MAX_OUT.
- Issue condition: !c0TxAlmFull && any Eligible.
- Grant: first eligible index at or after rr pointer, wrapping modulo NUM_REQ. req_ready is combinational and asserted the same cycle; the requester drops or advances its request on the following edge. rr pointer becomes grant+1 (mod NUM_REQ) on each issue; it is unchanged when nothing issues.
- Request output is registered, latency 1: c0tx_valid/addr/mdata are driven on the cycle after the grant. c0tx_valid is high exactly one cycle per grant.
- mdata[ID_W-1:0] = requester index. mdata[15:ID_W] = 16-ID_W-bit global sequence counter, incremented per issue, wraps silently. The sequence counter is for debug only; response routing ignores it.
- Response path is registered, latency 1: when c0rx_valid, rsp_valid[c0rx_mdata[ID_W-1:0]] pulses and rsp_data = c0rx_data. rsp_data holds its value otherwise.
- Counters:
  - Counter i increments on grant i and decrements on a response to i.
  - A simultaneous grant and response for the same i leaves the count unchanged.
  - A response to a zero count leaves the count at 0 and sets err_underflow.
- Counters saturate; they never exceed MAX_OUT because grants are gated by Eligible.
- c0TxAlmFull is honoured in the grant cycle only; a request already registered still issues next cycle. This relies on CCI-P almost-full slack of at least 8.
- Reset mid-operation:
  - All state clears; reset wins over simultaneous events.
  - Responses to pre-reset requests arriving after reset are still routed to rsp_valid, but they hit zero counters and set err_underflow.
  - Software must drain (idle=1) before issuing a soft reset.
- idle is combinational from counters and req_valid.

Decomposition:
- Shared package pipearch_common: NUM_REQ default, MAX_OUT default, and t_rd_mdata packed struct {seq, id}.
- Natural sub-module: rr_arbiter (NUM_REQ-wide round-robin grant from a request mask plus pointer; combinational grant, registered pointer). It is reusable for a later c1 write arbiter.

Test Plan:
- Reset, then req_valid=4'b1111 held for 8 cycles, almfull=0 → grants in order 0,1,2,3,0,1,2,3; c0tx_mdata[1:0] follows the same order; seq runs 0..7; outstanding = 2 each.
- req_valid=4'b0101, rr pointer=1 → grant 2, then 0, then 2; requesters 1 and 3 never granted.
- c0TxAlmFull=1 for 10 cycles with all requesters valid → no req_ready and no c0tx_valid; the grant after release goes to the pointer index.
- Requester 0 issues 64 reads with no responses → the 65th is blocked and outstanding[0]=64; one response with mdata id=0 → the grant resumes the next cycle.
- Same-cycle grant to 2 and response with id=2 → outstanding[2] unchanged; rsp_valid=4'b0100 and rsp_data = input data, one cycle later.
- Response with id=3 while outstanding[3]=0 → err_underflow=1 and stays 1 until reset; assert reset mid-burst → all outputs return to reset values on the next edge.
